chase_tick_ctrl: RTL and testbench

CHASE_TICK_CTRL -- requirements
Module: chase_tick_ctrl

---
 rtl/chase_pkg.sv | 24 ++
 rtl/chase_debounce.sv | 101 ++++++++++
 rtl/chase_tick_ctrl.sv | 70 +++++++
 tb/tb_chase_tick_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/chase_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// chase_pkg : shared constants and debounce state encoding for the LED chaser
// Rev 1.0
// ---------------------------------------------------------------------------
package chase_pkg;

  localparam int DIV_BASE_DEF  = 100_000;
  localparam int DB_CYCLES_DEF = 1_000_000;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    HELD       = 2'd2,
    DB_RELEASE = 2'd3
  } db_state_t;

  // Counter width for a modulus of n, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/chase_debounce.sv
`default_nettype none
// ---------------------------------------------------------------------------
// chase_debounce : 2-flop synchronizer plus press/release debounce FSM
// Rev 1.0
// ---------------------------------------------------------------------------
module chase_debounce
  import chase_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int DB_W = cnt_width(DB_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

  logic            sync_meta;
  logic            sync;
  db_state_t       state;
  db_state_t       state_nxt;
  logic [DB_W-1:0] db_cnt;
  logic [DB_W-1:0] db_cnt_nxt;
  logic            press_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_meta <= 1'b0;
      sync      <= 1'b0;
    end else begin
      sync_meta <= btn;
      sync      <= sync_meta;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      db_cnt <= '0;
      press  <= 1'b0;
    end else begin
      state  <= state_nxt;
      db_cnt <= db_cnt_nxt;
      press  <= press_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    db_cnt_nxt = db_cnt;
    press_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (sync) begin
          state_nxt  = DB_PRESS;
          db_cnt_nxt = '0;
        end
      end
      DB_PRESS: begin
        if (!sync) begin
          state_nxt  = IDLE;
          db_cnt_nxt = '0;
        end else if (db_cnt == DB_LAST) begin
          // The strobe is registered alongside the move to HELD, so it is
          // high in exactly the cycle the FSM first sits in HELD.
          state_nxt  = HELD;
          db_cnt_nxt = '0;
          press_nxt  = 1'b1;
        end else begin
          db_cnt_nxt = db_cnt + DB_ONE;
        end
      end
      HELD: begin
        if (!sync) begin
          state_nxt  = DB_RELEASE;
          db_cnt_nxt = '0;
        end
      end
      DB_RELEASE: begin
        if (sync) begin
          state_nxt  = HELD;
          db_cnt_nxt = '0;
        end else if (db_cnt == DB_LAST) begin
          state_nxt  = IDLE;
          db_cnt_nxt = '0;
        end else begin
          db_cnt_nxt = db_cnt + DB_ONE;
        end
      end
      default: begin
        state_nxt  = IDLE;
        db_cnt_nxt = '0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/chase_tick_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// chase_tick_ctrl : chase-speed prescaler with debounced stop/run toggle
// Rev 1.0
// ---------------------------------------------------------------------------
module chase_tick_ctrl
  import chase_pkg::*;
#(
  parameter int DIV_BASE  = DIV_BASE_DEF,
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_stop,
  input  logic [3:0] speed_sel,
  output logic       m_tick,
  output logic       stop,
  output logic       press
);

  localparam int TW = cnt_width(16 * DIV_BASE);
  localparam logic [TW-1:0] BASE     = TW'(DIV_BASE);
  localparam logic [TW-1:0] BASE_M1  = TW'(DIV_BASE - 1);
  localparam logic [TW-1:0] TICK_ONE = TW'(1);

  logic [TW-1:0] tick_cnt;
  logic [TW-1:0] period_m1;
  logic          tick_hit;

  chase_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_debounce (
    .clk  (clk),
    .reset(reset),
    .btn  (btn_stop),
    .press(press)
  );

  // P-1 = speed_sel*DIV_BASE + (DIV_BASE-1) tops out at 16*DIV_BASE-1,
  // so it always fits in TW bits without an intermediate carry bit.
  assign period_m1 = TW'(speed_sel) * BASE + BASE_M1;
  assign tick_hit  = (tick_cnt >= period_m1);

  // m_tick is registered: the compare made in a cycle (against the live
  // speed_sel) produces the strobe on the following edge, together with the
  // counter wrap. A press in that same cycle does not mask it, since stop
  // itself only flips on that edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
      m_tick   <= 1'b0;
      stop     <= 1'b0;
    end else begin
      if (press) begin
        stop <= ~stop;
      end
      if (stop) begin
        m_tick <= 1'b0;
      end else if (tick_hit) begin
        m_tick   <= 1'b1;
        tick_cnt <= '0;
      end else begin
        m_tick   <= 1'b0;
        tick_cnt <= tick_cnt + TICK_ONE;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_chase_tick_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_chase_tick_ctrl : directed self-checking bench, DIV_BASE=4, DB_CYCLES=8
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_chase_tick_ctrl;

  localparam int DIV_BASE  = 4;
  localparam int DB_CYCLES = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_stop;
  logic [3:0] speed_sel;
  logic       m_tick;
  logic       stop;
  logic       press;

  int   n_checks     = 0;
  int   n_fail       = 0;
  int   press_count  = 0;
  int   double_ticks = 0;
  logic prev_tick    = 1'b0;

  always #5 clk = ~clk;

  chase_tick_ctrl #(
    .DIV_BASE (DIV_BASE),
    .DB_CYCLES(DB_CYCLES)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_stop (btn_stop),
    .speed_sel(speed_sel),
    .m_tick   (m_tick),
    .stop     (stop),
    .press    (press)
  );

  always @(negedge clk) begin
    if (press === 1'b1) press_count <= press_count + 1;
    if (prev_tick && (m_tick === 1'b1)) double_ticks <= double_ticks + 1;
    prev_tick <= (m_tick === 1'b1);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset     = 1'b1;
    btn_stop  = 1'b0;
    speed_sel = 4'd0;
    #2 reset = 1'b0;
    #1;
    check("rst_m_tick", m_tick, 0);
    check("rst_stop", stop, 0);
    check("rst_press", press, 0);
    step(2);
    check("rst_hold_m_tick", m_tick, 0);
    reset = 1'b0;

    // Release reset; E1 is the next rising edge. Period 4 -> strobe at edge 4.
    reset = 1'b1;
    step(1);
    check("p4_e1", m_tick, 0);
    step(2);
    check("p4_e3", m_tick, 0);
    step(1);
    check("p4_first", m_tick, 1);
    for (int i = 1; i <= 8; i++) begin
      step(1);
      check("p4_run", m_tick, ((i % 4) == 0) ? 1 : 0);
    end

    // speed_sel=3 right after a strobe: period 16.
    speed_sel = 4'd3;
    for (int i = 1; i <= 32; i++) begin
      step(1);
      check("p16_run", m_tick, ((i % 16) == 0) ? 1 : 0);
    end

    // Counter at 10 with period 16, switch to period 4: strobe on the next edge.
    step(10);
    check("sw_before", m_tick, 0);
    speed_sel = 4'd0;
    step(1);
    check("sw_immediate", m_tick, 1);
    for (int i = 1; i <= 8; i++) begin
      step(1);
      check("sw_p4", m_tick, ((i % 4) == 0) ? 1 : 0);
    end

    // Bouncing press: 1,0,1,0 for 3 cycles each, then steady 1 for 20 cycles.
    step(2);
    check("pre_bounce_m_tick", m_tick, 0);
    btn_stop = 1'b1; step(3);
    btn_stop = 1'b0; step(3);
    btn_stop = 1'b1; step(3);
    btn_stop = 1'b0; step(3);
    check("bounce_no_press", press_count, 0);
    btn_stop = 1'b1;
    step(10);
    check("db_press_wait", press, 0);
    check("db_tick_before_stop", m_tick, 1);
    step(1);
    check("db_press_strobe", press, 1);
    check("db_stop_not_yet", stop, 0);
    step(1);
    check("db_press_one_cycle", press, 0);
    check("db_stop_set", stop, 1);
    for (int i = 0; i < 8; i++) begin
      step(1);
      check("stopped_silent", m_tick, 0);
    end
    check("held_one_press", press_count, 1);

    // Release with a one-cycle bounce high during DB_RELEASE.
    btn_stop = 1'b0;
    step(4);
    btn_stop = 1'b1;
    step(1);
    btn_stop = 1'b0;
    step(17);
    check("rel_bounce_no_press", press_count, 1);
    check("rel_stop_kept", stop, 1);
    check("rel_m_tick", m_tick, 0);

    // Clean second press: counter resumes from held value 2.
    btn_stop = 1'b1;
    step(10);
    check("p2_wait", press, 0);
    step(1);
    check("p2_strobe", press, 1);
    check("p2_stop_still", stop, 1);
    step(1);
    check("p2_stop_clear", stop, 0);
    check("p2_m_tick0", m_tick, 0);
    step(1);
    check("p2_cnt3", m_tick, 0);
    step(1);
    check("p2_resume_tick", m_tick, 1);
    step(1);
    check("p2_after_tick", m_tick, 0);
    step(3);
    check("p2_next_tick", m_tick, 1);
    btn_stop = 1'b0;
    step(15);
    check("p2_count", press_count, 2);

    // Reset mid-DB_PRESS with the button held through reset release.
    btn_stop = 1'b1;
    step(5);
    reset = 1'b0;
    #1;
    check("mid_rst_m_tick", m_tick, 0);
    check("mid_rst_stop", stop, 0);
    check("mid_rst_press", press, 0);
    step(3);
    check("mid_rst_no_press", press_count, 2);
    reset = 1'b1;
    step(3);
    check("rr_e3_m_tick", m_tick, 0);
    check("rr_e3_press", press, 0);
    step(1);
    check("rr_first_tick", m_tick, 1);
    step(6);
    check("rr_press_wait", press, 0);
    step(1);
    check("rr_press", press, 1);
    check("rr_press_m_tick", m_tick, 0);
    step(1);
    check("rr_tick_with_press", m_tick, 1);
    check("rr_stop_set", stop, 1);
    for (int i = 0; i < 8; i++) begin
      step(1);
      check("rr_stopped", m_tick, 0);
    end
    check("final_press_count", press_count, 3);
    check("no_double_tick", double_ticks, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
